// File: rtl/avs_wait_state_ram.sv
// Avalon-MM word RAM responder with programmable read/write wait states,
// extra STALL backpressure, transfer counters and a sticky protocol/range error flag.
module avs_wait_state_ram #(
   parameter int AVS_AVALONSLAVE_DATA_WIDTH    = 32,
   parameter int AVS_AVALONSLAVE_ADDRESS_WIDTH = 32,
   parameter int MEM_WORDS_LOG2                = 10,
   parameter logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0] BASE_ADDR = '0,
   parameter int RD_WAIT                       = 2,
   parameter int WR_WAIT                       = 1
) (
   input  logic                                     CSI_CLOCK_CLK,
   input  logic                                     CSI_CLOCK_RESET,
   input  logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0] AVS_AVALONSLAVE_ADDRESS,
   input  logic                                     AVS_AVALONSLAVE_READ,
   input  logic                                     AVS_AVALONSLAVE_WRITE,
   input  logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_WRITEDATA,
   output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_READDATA,
   output logic                                     AVS_AVALONSLAVE_WAITREQUEST,
   input  logic                                     STALL,
   output logic [31:0]                              RD_COUNT,
   output logic [31:0]                              WR_COUNT,
   output logic                                     ERROR
);

   localparam int AW    = AVS_AVALONSLAVE_ADDRESS_WIDTH;
   localparam int DW    = AVS_AVALONSLAVE_DATA_WIDTH;
   localparam int DEPTH = 2 ** MEM_WORDS_LOG2;
   localparam int CW    = 16;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t                    state, state_next;
   logic [CW-1:0]             cnt, cnt_next, load_cnt;
   logic [AW-1:0]             addr_q, op_addr, op_off;
   logic                      wr_q, op_wr, op_in_range, req, enter_ack;
   logic [MEM_WORDS_LOG2-1:0] op_idx;
   logic [DW-1:0]             mem [0:DEPTH-1];

   assign req = AVS_AVALONSLAVE_READ | AVS_AVALONSLAVE_WRITE;
   assign AVS_AVALONSLAVE_WAITREQUEST = req & (state != ACK);
   assign load_cnt = AVS_AVALONSLAVE_WRITE ? CW'(WR_WAIT - 1) : CW'(RD_WAIT - 1);

   // With a single wait state the transfer commits straight from IDLE, so the
   // live bus address/command is used there instead of the latched copy.
   assign op_addr     = (state == IDLE) ? AVS_AVALONSLAVE_ADDRESS : addr_q;
   assign op_wr       = (state == IDLE) ? AVS_AVALONSLAVE_WRITE : wr_q;
   assign op_off      = op_addr - BASE_ADDR;
   assign op_in_range = (op_addr >= BASE_ADDR) && ((op_off >> (MEM_WORDS_LOG2 + 2)) == '0);
   assign op_idx      = op_off[MEM_WORDS_LOG2+1:2];

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               cnt_next   = load_cnt;
               state_next = (load_cnt != '0) ? WAIT : ACK;
            end
         end
         WAIT: begin
            if (!req) begin
               state_next = IDLE;
            end else if (!STALL) begin
               cnt_next = cnt - CW'(1);
               if (cnt == CW'(1)) state_next = ACK;
            end
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign enter_ack = (state_next == ACK);

   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (CSI_CLOCK_RESET) begin
         state                    <= IDLE;
         cnt                      <= '0;
         addr_q                   <= '0;
         wr_q                     <= 1'b0;
         AVS_AVALONSLAVE_READDATA <= '0;
         RD_COUNT                 <= '0;
         WR_COUNT                 <= '0;
         ERROR                    <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (state == IDLE && req) begin
            addr_q <= AVS_AVALONSLAVE_ADDRESS;
            wr_q   <= AVS_AVALONSLAVE_WRITE;
            if ((AVS_AVALONSLAVE_READ & AVS_AVALONSLAVE_WRITE) | !op_in_range) ERROR <= 1'b1;
         end
         if (state == WAIT && !req) ERROR <= 1'b1;
         if (enter_ack && !op_wr)
            AVS_AVALONSLAVE_READDATA <= op_in_range ? mem[op_idx] : DW'(32'hDEAD_BEEF);
         if (state == ACK) begin
            if (wr_q) WR_COUNT <= WR_COUNT + 32'd1;
            else      RD_COUNT <= RD_COUNT + 32'd1;
         end
      end
   end

   // RAM contents survive reset; a reset cycle suppresses any pending commit.
   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (!CSI_CLOCK_RESET && enter_ack && op_wr && op_in_range)
         mem[op_idx] <= AVS_AVALONSLAVE_WRITEDATA;
   end

endmodule

// File: tb/tb_avs_wait_state_ram.sv
// Self-checking bench for avs_wait_state_ram: directed transfers against a
// transaction-level model, compared every cycle, plus literal spot checks.
module tb_avs_wait_state_ram;

   localparam int          RD_WAIT = 2;
   localparam int          WR_WAIT = 3;
   localparam logic [31:0] BASE    = 32'h0000_1000;
   localparam int          DEPTH   = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        waitreq;
   logic        stall = 1'b0;
   logic [31:0] rd_count, wr_count;
   logic        error;

   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   logic        exp_wait = 1'b0;
   logic        exp_error = 1'b0;
   logic [31:0] exp_rdata = '0;
   logic [31:0] exp_rd_cnt = '0;
   logic [31:0] exp_wr_cnt = '0;
   logic [31:0] model_mem [int];
   int          high_run = 0;
   int          last_run = 0;

   avs_wait_state_ram #(
      .AVS_AVALONSLAVE_DATA_WIDTH(32),
      .AVS_AVALONSLAVE_ADDRESS_WIDTH(32),
      .MEM_WORDS_LOG2(10),
      .BASE_ADDR(BASE),
      .RD_WAIT(RD_WAIT),
      .WR_WAIT(WR_WAIT)
   ) dut (
      .CSI_CLOCK_CLK(clk),
      .CSI_CLOCK_RESET(rst),
      .AVS_AVALONSLAVE_ADDRESS(addr),
      .AVS_AVALONSLAVE_READ(rd),
      .AVS_AVALONSLAVE_WRITE(wr),
      .AVS_AVALONSLAVE_WRITEDATA(wdata),
      .AVS_AVALONSLAVE_READDATA(rdata),
      .AVS_AVALONSLAVE_WAITREQUEST(waitreq),
      .STALL(stall),
      .RD_COUNT(rd_count),
      .WR_COUNT(wr_count),
      .ERROR(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("waitrequest", 32'(waitreq), 32'(exp_wait));
         check("readdata", rdata, exp_rdata);
         check("rd_count", rd_count, exp_rd_cnt);
         check("wr_count", wr_count, exp_wr_cnt);
         check("error", 32'(error), 32'(exp_error));
      end
      if (waitreq) high_run++;
      else if (high_run != 0) begin
         last_run = high_run;
         high_run = 0;
      end
   end

   function automatic bit in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a >= BASE) && ((off >> 2) < 32'(DEPTH));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit s);
      rd    = r;
      wr    = w;
      addr  = a;
      wdata = d;
      stall = s;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, '0, '0, 1'b0);
         exp_wait = 1'b0;
         step();
      end
   endtask

   // One complete transfer: WAIT_n + stall_len busy cycles, then the ack cycle.
   task automatic transfer(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                           input int stall_at, input int stall_len);
      int high;
      bit bad;
      int idx;
      high = (w ? WR_WAIT : RD_WAIT) + stall_len;
      bad  = !in_range(a);
      idx  = int'((a - BASE) >> 2);
      for (int k = 0; k <= high; k++) begin
         drive(r, w, a, d, (k >= stall_at) && (k < stall_at + stall_len));
         if (k >= 1 && (bad || (r && w))) exp_error = 1'b1;
         exp_wait = (k < high);
         if (k == high && !w) exp_rdata = bad ? 32'hDEAD_BEEF : model_mem[idx];
         step();
      end
      if (w) begin
         if (!bad) model_mem[idx] = d;
         exp_wr_cnt++;
      end else begin
         exp_rd_cnt++;
      end
   endtask

   task automatic applyStimulus_abort(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold);
      for (int k = 0; k < hold; k++) begin
         drive(!w, w, a, d, 1'b0);
         exp_wait = 1'b1;
         step();
      end
      drive(1'b0, 1'b0, a, d, 1'b0);
      exp_wait = 1'b0;
      step();
      exp_error = 1'b1;
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      step();
      rst        = 1'b0;
      exp_wait   = 1'b0;
      exp_rdata  = '0;
      exp_rd_cnt = '0;
      exp_wr_cnt = '0;
      exp_error  = 1'b0;
      chk_en     = 1'b1;
   endtask

   initial begin
      do_reset();
      idle(1);
      check("reset readdata", rdata, 32'h0);
      check("reset rd_count", rd_count, 32'h0);

      // Single write then readback
      transfer(1'b1, 1'b0, BASE + 32'h10, 32'h0000_1234, 0, 0);
      check("write busy cycles", 32'(last_run), 32'd3);
      idle(1);
      check("wr_count after one write", wr_count, 32'd1);
      transfer(1'b0, 1'b1, BASE + 32'h10, '0, 0, 0);
      check("read busy cycles", 32'(last_run), 32'd2);
      check("readback 0x10", rdata, 32'h0000_1234);
      idle(1);

      // 64-bit result as back-to-back word pair
      transfer(1'b1, 1'b0, BASE + 32'h20, 32'hAAAA_0001, 0, 0);
      transfer(1'b1, 1'b0, BASE + 32'h24, 32'h0000_0002, 0, 0);
      transfer(1'b0, 1'b1, BASE + 32'h20, '0, 0, 0);
      check("readback 0x20", rdata, 32'hAAAA_0001);
      transfer(1'b0, 1'b1, BASE + 32'h24, '0, 0, 0);
      check("readback 0x24", rdata, 32'h0000_0002);
      idle(1);
      check("wr_count after pair", wr_count, 32'd3);
      check("error clear after pair", 32'(error), 32'd0);

      // STALL stretching reads and writes; low address bits ignored
      transfer(1'b0, 1'b1, BASE + 32'h20, '0, 1, 3);
      check("stalled read busy cycles", 32'(last_run), 32'd5);
      transfer(1'b1, 1'b0, BASE + 32'h28, 32'h0000_CAFE, 1, 2);
      transfer(1'b0, 1'b1, BASE + 32'h2B, '0, 0, 0);
      check("readback unaligned 0x2B", rdata, 32'h0000_CAFE);
      idle(1);

      // Reset while a write sits in WAIT
      drive(1'b0, 1'b1, BASE + 32'h10, 32'h0000_5555, 1'b0);
      exp_wait = 1'b1;
      step();
      do_reset();
      idle(1);
      check("wr_count after mid-write reset", wr_count, 32'd0);
      transfer(1'b0, 1'b1, BASE + 32'h10, '0, 0, 0);
      check("target word unchanged by reset", rdata, 32'h0000_1234);
      idle(1);

      // Out-of-range accesses
      transfer(1'b0, 1'b1, BASE + 32'd4096, '0, 0, 0);
      check("oob read data", rdata, 32'hDEAD_BEEF);
      check("oob read error", 32'(error), 32'd1);
      transfer(1'b1, 1'b0, BASE + 32'd4096 + 32'h10, 32'h0000_FFFF, 0, 0);
      transfer(1'b0, 1'b1, BASE + 32'h10, '0, 0, 0);
      check("word kept after oob write", rdata, 32'h0000_1234);
      transfer(1'b0, 1'b1, 32'h0000_0FF0, '0, 0, 0);
      check("below-base read data", rdata, 32'hDEAD_BEEF);
      idle(2);
      check("error sticky", 32'(error), 32'd1);
      do_reset();

      // Withdrawn requests and READ&WRITE together
      applyStimulus_abort(1'b1, BASE + 32'h24, 32'h0000_9999, 2);
      idle(1);
      check("abort write error", 32'(error), 32'd1);
      check("abort write not counted", wr_count, 32'd0);
      transfer(1'b0, 1'b1, BASE + 32'h24, '0, 0, 0);
      check("aborted write not committed", rdata, 32'h0000_0002);
      applyStimulus_abort(1'b0, BASE + 32'h20, '0, 1);
      idle(1);
      do_reset();
      transfer(1'b1, 1'b1, BASE + 32'h30, 32'h0000_0077, 0, 0);
      idle(1);
      check("read&write error", 32'(error), 32'd1);
      check("read&write counted as write", wr_count, 32'd1);
      check("read&write not counted as read", rd_count, 32'd0);
      transfer(1'b0, 1'b1, BASE + 32'h30, '0, 0, 0);
      check("read&write committed", rdata, 32'h0000_0077);
      idle(2);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
